// File: rtl/cla64_share_arb.sv
// Round-robin front end sharing one 64-bit KPG parallel-prefix adder among NREQ requesters.
// Operands are registered ahead of the adder (S1) and results behind it (S2), fully back-pressured.
module cla64_share_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic [IDW-1:0]       rsp_id
);

  typedef enum logic [1:0] {
    KPG_K = 2'b00,
    KPG_P = 2'b01,
    KPG_G = 2'b10
  } kpg_e;

  typedef struct packed {
    logic [63:0]    a;
    logic [63:0]    b;
    logic           cin;
    logic [IDW-1:0] id;
  } s1_t;

  typedef struct packed {
    logic [63:0]    sum;
    logic           cout;
    logic [IDW-1:0] id;
  } s2_t;

  function automatic kpg_e kpg_cell(input logic a, input logic b);
    if (a & b)      return KPG_G;
    else if (a ^ b) return KPG_P;
    else            return KPG_K;
  endfunction

  // A propagating upper group takes its carry status from the group below it.
  function automatic kpg_e kpg_join(input kpg_e hi, input kpg_e lo);
    return (hi == KPG_P) ? lo : hi;
  endfunction

  // Kogge-Stone prefix over 65 positions: position 0 is carry-in, position i+1 is bit i.
  // After the last level pre[i] is the resolved carry into bit i (always K or G).
  function automatic logic [64:0] kpg_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin);
    kpg_e        bit_code [0:64];
    kpg_e        pre      [0:64];
    kpg_e        nxt      [0:64];
    logic [63:0] sum;
    logic        cout;
    bit_code[0] = cin ? KPG_G : KPG_K;
    for (int i = 0; i < 64; i++) bit_code[i+1] = kpg_cell(a[i], b[i]);
    pre = bit_code;
    for (int d = 1; d <= 64; d = d * 2) begin
      for (int j = 0; j <= 64; j++) begin
        if (j >= d) nxt[j] = kpg_join(pre[j], pre[j-d]);
        else        nxt[j] = pre[j];
      end
      pre = nxt;
    end
    for (int i = 0; i < 64; i++) sum[i] = a[i] ^ b[i] ^ (pre[i] == KPG_G);
    cout = (bit_code[64] == KPG_G) | ((bit_code[64] == KPG_P) & (pre[63] == KPG_G));
    return {cout, sum};
  endfunction

  function automatic int rr_index(input logic [IDW-1:0] base, input int step);
    return (int'(base) + step) % NREQ;
  endfunction

  logic [IDW-1:0] last;
  logic [IDW-1:0] grant_id;
  logic [NREQ-1:0] grant;
  logic           grant_any;
  logic           s1_valid, s2_valid;
  logic           s1_free, s2_load, accept;
  s1_t            s1_q, s1_d;
  s2_t            s2_q;
  logic [63:0]    adder_sum;
  logic           adder_cout;

  // Search starts one past the last accepted requester and wraps.
  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_any && (j == rr_index(last, k)) && req_valid[j]) begin
          grant_any = 1'b1;
          grant_id  = IDW'(j);
          grant[j]  = 1'b1;
        end
      end
    end
  end

  assign s2_load   = s1_valid & (~s2_valid | rsp_ready);
  assign s1_free   = ~s1_valid | s2_load;
  assign req_ready = grant & {NREQ{s1_free & ~rst}};
  assign accept    = grant_any & s1_free & ~rst;

  always_comb begin
    s1_d    = '0;
    s1_d.id = grant_id;
    for (int j = 0; j < NREQ; j++) begin
      if (grant[j]) begin
        s1_d.a   = req_a[j*64 +: 64];
        s1_d.b   = req_b[j*64 +: 64];
        s1_d.cin = req_cin[j];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      last     <= IDW'(NREQ - 1);
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_q     <= s1_d;
      last     <= grant_id;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  assign {adder_cout, adder_sum} = kpg_add(s1_q.a, s1_q.b, s1_q.cin);

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_load) begin
      s2_valid   <= 1'b1;
      s2_q.sum   <= adder_sum;
      s2_q.cout  <= adder_cout;
      s2_q.id    <= s1_q.id;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign rsp_valid = s2_valid;
  assign rsp_sum   = s2_q.sum;
  assign rsp_cout  = s2_q.cout;
  assign rsp_id    = s2_q.id;

endmodule

// File: tb/tb_cla64_share_arb.sv
// Directed bench for cla64_share_arb: one NREQ=2 instance for most scenarios and an
// NREQ=3 instance for the wrap-around case; inputs driven 1ns after the rising edge, outputs sampled 2ns after.
module tb_cla64_share_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [1:0]   d2_valid, d2_ready, d2_cin;
  logic [127:0] d2_a, d2_b;
  logic         d2_rsp_valid, d2_rsp_ready, d2_rsp_cout;
  logic [63:0]  d2_rsp_sum;
  logic [1:0]   d2_rsp_id;

  logic [2:0]   d3_valid, d3_ready, d3_cin;
  logic [191:0] d3_a, d3_b;
  logic         d3_rsp_valid, d3_rsp_ready, d3_rsp_cout;
  logic [63:0]  d3_rsp_sum;
  logic [1:0]   d3_rsp_id;

  int errors = 0;
  int checks = 0;

  cla64_share_arb #(.NREQ(2), .IDW(2)) dut2 (
    .clk(clk), .rst(rst),
    .req_valid(d2_valid), .req_ready(d2_ready),
    .req_a(d2_a), .req_b(d2_b), .req_cin(d2_cin),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready),
    .rsp_sum(d2_rsp_sum), .rsp_cout(d2_rsp_cout), .rsp_id(d2_rsp_id)
  );

  cla64_share_arb #(.NREQ(3), .IDW(2)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(d3_valid), .req_ready(d3_ready),
    .req_a(d3_a), .req_b(d3_b), .req_cin(d3_cin),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready),
    .rsp_sum(d3_rsp_sum), .rsp_cout(d3_rsp_cout), .rsp_id(d3_rsp_id)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set2(input logic i, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic c);
    d2_valid[i]       = v;
    d2_a[{i, 6'b0} +: 64] = a;
    d2_b[{i, 6'b0} +: 64] = b;
    d2_cin[i]         = c;
  endtask

  task automatic set3(input logic [1:0] i, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic c);
    d3_valid[i]       = v;
    d3_a[{i, 6'b0} +: 64] = a;
    d3_b[{i, 6'b0} +: 64] = b;
    d3_cin[i]         = c;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    d2_valid = '0;
    d3_valid = '0;
    d2_rsp_ready = 1'b1;
    d3_rsp_ready = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    rst = 1'b1;
    d2_valid = '1;
    d3_valid = '1;
    d2_rsp_ready = 1'b0;
    d3_rsp_ready = 1'b0;
    #1;
    checks++;
    if (d2_ready !== 2'b00) begin errors++; $display("FAIL reset_ready2: got %b want 00", d2_ready); end
    checks++;
    if (d3_ready !== 3'b000) begin errors++; $display("FAIL reset_ready3: got %b want 000", d3_ready); end
    next_cycle();
    next_cycle();
    #1;
    checks++;
    if ({d2_rsp_valid, d2_rsp_cout, d2_rsp_id, d2_rsp_sum} !== 68'h0) begin
      errors++;
      $display("FAIL reset_rsp2: got v=%b c=%b id=%0d sum=%h want all zero",
               d2_rsp_valid, d2_rsp_cout, d2_rsp_id, d2_rsp_sum);
    end
    checks++;
    if ({d3_rsp_valid, d3_rsp_cout, d3_rsp_id, d3_rsp_sum} !== 68'h0) begin
      errors++;
      $display("FAIL reset_rsp3: got v=%b c=%b id=%0d sum=%h want all zero",
               d3_rsp_valid, d3_rsp_cout, d3_rsp_id, d3_rsp_sum);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (d2_ready !== 2'b01) begin errors++; $display("FAIL reset_prio2: got %b want 01", d2_ready); end
    checks++;
    if (d3_ready !== 3'b001) begin errors++; $display("FAIL reset_prio3: got %b want 001", d3_ready); end
    d2_valid = '0;
    d3_valid = '0;
    d2_rsp_ready = 1'b1;
    d3_rsp_ready = 1'b1;
  endtask

  task automatic test_single_add(input string name, input logic i, input logic [63:0] a,
                                 input logic [63:0] b, input logic c,
                                 input logic [63:0] exp_sum, input logic exp_cout);
    logic [67:0] exp_rsp;
    exp_rsp = {1'b1, exp_cout, 1'b0, i, exp_sum};
    next_cycle();
    d2_rsp_ready = 1'b1;
    set2(i, 1'b1, a, b, c);
    #1;
    checks++;
    if (d2_ready !== (i ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL %s_ready: got %b want %b", name, d2_ready, (i ? 2'b10 : 2'b01));
    end
    next_cycle();
    set2(i, 1'b0, a, b, c);
    #1;
    checks++;
    if (d2_rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_early: rsp_valid got %b want 0", name, d2_rsp_valid); end
    next_cycle();
    #1;
    checks++;
    if ({d2_rsp_valid, d2_rsp_cout, d2_rsp_id, d2_rsp_sum} !== exp_rsp) begin
      errors++;
      $display("FAIL %s_rsp: got v=%b c=%b id=%0d sum=%h want v=1 c=%b id=%0d sum=%h",
               name, d2_rsp_valid, d2_rsp_cout, d2_rsp_id, d2_rsp_sum, exp_cout, i, exp_sum);
    end
    next_cycle();
    #1;
    checks++;
    if (d2_rsp_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: rsp_valid got %b want 0", name, d2_rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_ready;
    logic [67:0] exp_rsp;
    do_reset();
    set2(1'b0, 1'b1, 64'd10, 64'd1, 1'b0);
    set2(1'b1, 1'b1, 64'd20, 64'd2, 1'b1);
    d2_rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) d2_valid = '0;
      #1;
      exp_ready = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      checks++;
      if (d2_ready !== exp_ready) begin
        errors++; $display("FAIL fair_ready[%0d]: got %b want %b", k, d2_ready, exp_ready);
      end
      if (k >= 2 && k < 6) begin
        exp_rsp = ((k - 2) % 2 == 0) ? {1'b1, 1'b0, 2'd0, 64'd11} : {1'b1, 1'b0, 2'd1, 64'd23};
        checks++;
        if ({d2_rsp_valid, d2_rsp_cout, d2_rsp_id, d2_rsp_sum} !== exp_rsp) begin
          errors++;
          $display("FAIL fair_rsp[%0d]: got v=%b id=%0d sum=%h want id=%0d sum=%h", k,
                   d2_rsp_valid, d2_rsp_id, d2_rsp_sum, exp_rsp[65:64], exp_rsp[63:0]);
        end
      end else begin
        checks++;
        if (d2_rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_idle[%0d]: rsp_valid got %b want 0", k, d2_rsp_valid); end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int          accepts;
    logic        exp_ready;
    logic        exp_v;
    logic [63:0] exp_sum;
    do_reset();
    accepts = 0;
    d2_rsp_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: set2(1'b0, 1'b1, 64'd100, 64'd1, 1'b0);
        1: set2(1'b0, 1'b1, 64'd200, 64'd2, 1'b0);
        2: set2(1'b0, 1'b1, 64'd300, 64'd3, 1'b0);
        5: d2_rsp_ready = 1'b1;
        6: d2_valid = '0;
        default: ;
      endcase
      #1;
      exp_ready = (k <= 1 || k == 5);
      case (k)
        0, 1, 8:    begin exp_v = 1'b0; exp_sum = 64'd0;   end
        2, 3, 4, 5: begin exp_v = 1'b1; exp_sum = 64'd101; end
        6:          begin exp_v = 1'b1; exp_sum = 64'd202; end
        default:    begin exp_v = 1'b1; exp_sum = 64'd303; end
      endcase
      if (k < 5 && d2_ready[0]) accepts++;
      checks++;
      if (d2_ready !== {1'b0, exp_ready}) begin
        errors++; $display("FAIL bp_ready[%0d]: got %b want 0%b", k, d2_ready, exp_ready);
      end
      checks++;
      if (d2_rsp_valid !== exp_v || (exp_v && (d2_rsp_sum !== exp_sum || d2_rsp_id !== 2'd0))) begin
        errors++;
        $display("FAIL bp_rsp[%0d]: got v=%b id=%0d sum=%0d want v=%b id=0 sum=%0d", k,
                 d2_rsp_valid, d2_rsp_id, d2_rsp_sum, exp_v, exp_sum);
      end
      next_cycle();
    end
    checks++;
    if (accepts !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    d2_rsp_ready = 1'b0;
    set2(1'b0, 1'b1, 64'd100, 64'd1, 1'b0);
    next_cycle();
    set2(1'b0, 1'b1, 64'd200, 64'd2, 1'b0);
    next_cycle();
    rst = 1'b1;
    set2(1'b0, 1'b1, 64'd7, 64'd7, 1'b0);
    set2(1'b1, 1'b1, 64'd9, 64'd9, 1'b0);
    #1;
    checks++;
    if (d2_ready !== 2'b00 || d2_rsp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full: got ready=%b v=%b want ready=00 v=1", d2_ready, d2_rsp_valid);
    end
    next_cycle();
    rst = 1'b0;
    d2_rsp_ready = 1'b1;
    #1;
    checks++;
    if (d2_rsp_valid !== 1'b0 || d2_ready !== 2'b01) begin
      errors++; $display("FAIL mid_after: got v=%b ready=%b want v=0 ready=01", d2_rsp_valid, d2_ready);
    end
    next_cycle();
    d2_valid = '0;
    #1;
    checks++;
    if (d2_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale1: rsp_valid got %b want 0", d2_rsp_valid); end
    next_cycle();
    #1;
    checks++;
    if ({d2_rsp_valid, d2_rsp_id, d2_rsp_sum} !== {1'b1, 2'd0, 64'd14}) begin
      errors++; $display("FAIL mid_new: got v=%b id=%0d sum=%0d want v=1 id=0 sum=14", d2_rsp_valid, d2_rsp_id, d2_rsp_sum);
    end
    next_cycle();
    #1;
    checks++;
    if (d2_rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale2: rsp_valid got %b want 0", d2_rsp_valid); end
  endtask

  task automatic test_wrap3();
    do_reset();
    d3_rsp_ready = 1'b1;
    set3(2'd2, 1'b1, 64'd1, 64'd2, 1'b0);
    #1;
    checks++;
    if (d3_ready !== 3'b100) begin errors++; $display("FAIL wrap_r2: got %b want 100", d3_ready); end
    next_cycle();
    d3_valid = '0;
    #1;
    checks++;
    if (d3_ready !== 3'b000) begin errors++; $display("FAIL wrap_idle: got %b want 000", d3_ready); end
    next_cycle();
    set3(2'd0, 1'b1, 64'd4, 64'd5, 1'b0);
    set3(2'd1, 1'b1, 64'd6, 64'd6, 1'b1);
    #1;
    checks++;
    if (d3_ready !== 3'b001) begin errors++; $display("FAIL wrap_r0: got %b want 001", d3_ready); end
    checks++;
    if ({d3_rsp_valid, d3_rsp_id, d3_rsp_sum} !== {1'b1, 2'd2, 64'd3}) begin
      errors++; $display("FAIL wrap_rsp2: got v=%b id=%0d sum=%0d want v=1 id=2 sum=3", d3_rsp_valid, d3_rsp_id, d3_rsp_sum);
    end
    next_cycle();
    d3_valid[0] = 1'b0;
    #1;
    checks++;
    if (d3_ready !== 3'b010) begin errors++; $display("FAIL wrap_r1: got %b want 010", d3_ready); end
    checks++;
    if (d3_rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_gap: rsp_valid got %b want 0", d3_rsp_valid); end
    next_cycle();
    d3_valid = '0;
    #1;
    checks++;
    if ({d3_rsp_valid, d3_rsp_id, d3_rsp_sum} !== {1'b1, 2'd0, 64'd9}) begin
      errors++; $display("FAIL wrap_rsp0: got v=%b id=%0d sum=%0d want v=1 id=0 sum=9", d3_rsp_valid, d3_rsp_id, d3_rsp_sum);
    end
    next_cycle();
    #1;
    checks++;
    if ({d3_rsp_valid, d3_rsp_id, d3_rsp_sum} !== {1'b1, 2'd1, 64'd13}) begin
      errors++; $display("FAIL wrap_rsp1: got v=%b id=%0d sum=%0d want v=1 id=1 sum=13", d3_rsp_valid, d3_rsp_id, d3_rsp_sum);
    end
    next_cycle();
    #1;
    checks++;
    if (d3_rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: rsp_valid got %b want 0", d3_rsp_valid); end
  endtask

  initial begin
    rst = 1'b1;
    d2_valid = '0; d2_a = '0; d2_b = '0; d2_cin = '0; d2_rsp_ready = 1'b0;
    d3_valid = '0; d3_a = '0; d3_b = '0; d3_cin = '0; d3_rsp_ready = 1'b0;
    test_reset();
    test_single_add("add_small", 1'b0, 64'h5, 64'h3, 1'b0, 64'h8, 1'b0);
    test_single_add("add_ripple", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1);
    test_single_add("add_msb", 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1);
    test_single_add("add_to_msb", 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0);
    test_single_add("add_mid", 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0);
    test_single_add("add_mixed", 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1);
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    test_wrap3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla64_share_arb.md
# cla64_share_arb

Shared-resource front end for the 64-bit KPG parallel-prefix adder in the FPM pipeline. Arbitrates up to four requesters (mantissa final-add, rounding increment, exponent adjust, spare) onto one adder instance with round-robin fairness. Registers operands ahead of the adder and registers results behind it, giving a two-stage, fully back-pressured pipeline. Returns each sum tagged with the requester index.

## Interface
Parameters:
- NREQ, 2: number of requesters, legal range 2..4.
- IDW, 2: width of the requester tag; must satisfy 2^IDW >= NREQ.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request present, one bit per requester.
- req_ready  output  NREQ  request accepted this cycle, one-hot or zero.
- req_a  input  NREQ*64  operand A, requester i at bits [64i+63:64i].
- req_b  input  NREQ*64  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in per requester.
- rsp_valid  output  1  result register holds a valid sum.
- rsp_ready  input  1  consumer takes the result this cycle.
- rsp_sum  output  64  a+b+cin, low 64 bits.
- rsp_cout  output  1  carry-out of bit 63.
- rsp_id  output  IDW  index of the requester that issued this result.

## Operation
- Handshake on both sides is valid/ready. A transfer happens on a rising edge where valid and ready are both high.
- A requester holds valid, operands and cin stable until it is accepted. Dropping valid before acceptance is illegal.
- Round-robin pointer `last` holds the index of the most recently accepted requester.
- Grant search starts at last+1 and wraps modulo NREQ. The first requester found with valid high is granted.
- Grant is combinational from req_valid and `last`. It may move between requesters before acceptance, because nothing is committed until the handshake.
- `last` updates only on an accepted handshake.
- Stage 1 (S1) holds: s1_valid, a, b, cin, id.
- Carry-in encoding into the adder: cin=0 drives the kill code 'k'; cin=1 drives the generate code 'g'.
- The adder is combinational from S1 to stage 2 (S2). S2 holds: s2_valid, sum, cout, id. Outputs rsp_* come directly from S2.
- rsp_cout = 1 when the adder carry-out code is 'g', or when it is 'p' and the prefix at bit 63 is 'g'. Otherwise rsp_cout = 0.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | rsp_ready).
  - s1_free = !s1_valid | s2_load.
  - req_ready[i] = grant[i] & s1_free & !rst.
- S2 clears when rsp_ready is high and nothing loads into it. S1 clears when it advances and no new request is accepted.
- Arithmetic: unsigned modulo 2^64. Operands are never sign-extended.

## Timing
- Reset values:
  - s1_valid = 0, s2_valid = 0.
  - rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0.
  - req_ready = 0 while rst is high.
  - `last` = NREQ-1, so requester 0 has first priority after reset.
- Latency: a request accepted at the end of cycle c produces rsp_valid in cycle c+2.
- Throughput is one result per cycle while rsp_ready is held high.
- Backpressure with rsp_ready low and S2 full:
  - S2 holds its contents.
  - S1 holds its contents if full.
  - If S1 is empty, one more request is accepted into it. After that, all req_ready deassert.
  - Pipeline capacity is 2 results.
- A simultaneous rsp_ready and new accept in the same cycle is a legal full-rate pipeline move. No bubble is inserted.
- All req_valid low: no grant, `last` unchanged, and pipeline stages drain normally.
- Reset asserted mid-operation: in-flight S1 and S2 contents are discarded and no response is emitted for them. Requesters must re-present.
- Wrap-around: after requester NREQ-1 is accepted, requester 0 is searched first.

## Test plan
- Single add, req 0: a=0x0000_0000_0000_0005, b=0x3, cin=0 -> rsp_valid two cycles later with sum=0x8, cout=0, id=0.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. Also a=b=0x8000_0000_0000_0000, cin=0 -> sum=0, cout=1.
- Fairness, NREQ=2, both req_valid held high, rsp_ready=1 -> accepts alternate 0,1,0,1. rsp_id follows the same order, one result per cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles with req 0 streaming -> exactly 2 accepts. rsp_sum and rsp_id stay stable. On release, both results emerge in order with no loss.
- Reset mid-flight: assert rst for 1 cycle while S1 and S2 are full -> rsp_valid=0 the next cycle and no stale result appears. The next accept goes to requester 0 when all requesters are valid.
- NREQ=3 wrap: accept req 2, then present req 0 and req 1 together -> req 0 is granted first.
